sram_axi_bridge: RTL

Single-port responder that accepts sram-like requests from the instruction/data caches and converts each into one single-beat AXI3/AXI4 read or write transaction. It is the slave end of the cache-side `req/addr_ok/data_ok` handshake and the AXI master toward the interconnect. It keeps one transaction outstanding, latches the request on `addr_ok`, and returns read data combinationally from the AXI R channel on `data_ok`.

---
 rtl/sram_axi_bridge.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_axi_bridge.sv
// ---------------------------------------------------------------------------
// sram_axi_bridge
//   Slave end of the cache-side sram-like handshake (req/addr_ok/data_ok) and
//   single-beat AXI master toward the interconnect. Exactly one transaction
//   is outstanding; the request is captured on addr_ok and held until
//   data_ok. Read data is forwarded combinationally from the R channel.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req/wr/size/addr/wdata   sram-like request (held by requester until addr_ok)
//   rdata/addr_ok/data_ok    sram-like response
//   ar*/r*                   AXI read address / read data channels
//   aw*/w*/b*                AXI write address / write data / response channels
//   bus_err                  sticky error flag
//
// Build option
//   SRAM_AXI_ERR_EN  when defined, bus_err latches any non-OKAY rresp/bresp
//                    seen on a handshake; otherwise bus_err is tied low.
// ---------------------------------------------------------------------------
module sram_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata_axi,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata_axi,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic        bus_err
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

    state_t      r_state;
    state_t      w_state_next;
    // Direction is carried by the state itself, so only size/addr/wdata are kept.
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_aw_done;
    logic        r_w_done;
    logic        w_aw_hs;
    logic        w_w_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_size    <= 2'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (addr_ok) begin
                r_size    <= size;
                r_addr    <= addr;
                r_wdata   <= wdata;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        addr_ok      = 1'b0;
        data_ok      = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        w_aw_hs      = 1'b0;
        w_w_hs       = 1'b0;
        case (r_state)
            S_IDLE: begin
                addr_ok = req & ~rst;
                if (addr_ok) w_state_next = wr ? S_WR : S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) w_state_next = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    // A response landing in the reset cycle belongs to an
                    // abandoned transaction and must not be reported.
                    data_ok      = ~rst;
                    w_state_next = S_IDLE;
                end
            end
            S_WR: begin
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                w_aw_hs = awvalid & awready;
                w_w_hs  = wvalid & wready;
                // Both channels may complete in the same cycle, so the current
                // handshakes count alongside the recorded ones.
                if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) w_state_next = S_B;
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_ok      = ~rst;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_size)
            2'd0:    wstrb = 4'b0001 << r_addr[1:0];
            2'd1:    wstrb = 4'b0011 << r_addr[1:0];
            default: wstrb = 4'b1111;
        endcase
    end

    assign rdata     = rdata_axi;

    assign arid      = AXI_ID;
    assign araddr    = r_addr;
    assign arlen     = 8'd0;
    assign arsize    = {1'b0, r_size};
    assign arburst   = 2'b01;
    assign arlock    = 2'd0;
    assign arcache   = 4'd0;
    assign arprot    = 3'd0;

    assign awid      = AXI_ID;
    assign awaddr    = r_addr;
    assign awlen     = 8'd0;
    assign awsize    = {1'b0, r_size};
    assign awburst   = 2'b01;
    assign awlock    = 2'd0;
    assign awcache   = 4'd0;
    assign awprot    = 3'd0;

    assign wid       = AXI_ID;
    assign wdata_axi = r_wdata;
    assign wlast     = 1'b1;

`ifdef SRAM_AXI_ERR_EN
    logic r_bus_err;
    logic w_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_err <= 1'b0;
        end else if ((rready && rvalid && (rresp != 2'b00)) ||
                     (bready && bvalid && (bresp != 2'b00))) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err  = r_bus_err;
    // IDs and rlast carry no information with a single outstanding beat.
    assign w_unused = ^{rid, bid, rlast};
`else
    logic w_unused;

    assign bus_err  = 1'b0;
    assign w_unused = ^{rid, bid, rlast, rresp, bresp};
`endif

endmodule
